// File: rtl/xup_arb_pkg.sv
// xup_arb_pkg: shared constants, state encoding and pointer helper for the round-robin arbiter
package xup_arb_pkg;
    localparam int N_REQ = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return 2'((32'(idx) + 1) % N_REQ);
    endfunction
endpackage

// File: rtl/xup_rr_pick4.sv
// xup_rr_pick4: combinational rotating-priority picker over four masked requests
module xup_rr_pick4
    import xup_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic       found,
    output logic [1:0] idx
);
    logic [3:0] cand;
    logic [3:0] rot;
    logic [1:0] off;
    always_comb begin
        cand  = req & ~mask;
        rot   = 4'({cand, cand} >> ptr);
        off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        found = |cand;
        idx   = ptr + off;
    end
endmodule

// File: rtl/xup_rr_arbiter4.sv
// xup_rr_arbiter4: four-requester round-robin arbiter with grant hold and hold-time preemption
module xup_rr_arbiter4
    import xup_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       any_req,
    output logic       preempt
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] LIM = HW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d, gnt_id_q, gnt_id_d, pick_ptr, pick_idx;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    gnt_q, gnt_d, pick_mask;
    logic          gnt_valid_q, gnt_valid_d, preempt_q, preempt_d;
    logic          rel, tmo, at_lim, found;

    xup_rr_pick4 u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .found(found),
        .idx  (pick_idx)
    );

    always_comb begin
        any_req     = |req;
        at_lim      = (MAX_HOLD != 0) && (hold_q == LIM);
        rel         = (state_q == ST_GRANT) && !req[gnt_id_q];
        tmo         = (state_q == ST_GRANT) && req[gnt_id_q] && at_lim && |(req & ~gnt_q);
        pick_ptr    = (rel || tmo) ? rr_next(gnt_id_q) : ptr_q;
        pick_mask   = tmo ? gnt_q : 4'b0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = tmo;
        if (state_q == ST_IDLE || rel || tmo) begin
            ptr_d    = pick_ptr;
            hold_d   = '0;
            state_d  = found ? ST_GRANT : ST_IDLE;
            gnt_d    = found ? 4'b1 << pick_idx : 4'b0;
            gnt_id_d = found ? pick_idx : gnt_id_q;
        end else begin
            // a lone owner at the limit keeps the grant and starts a fresh hold window
            hold_d = (MAX_HOLD == 0 || at_lim) ? '0 : hold_q + HW'(1);
        end
        gnt_valid_d = (state_d == ST_GRANT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;
endmodule

// File: tb/tb_xup_rr_arbiter4.sv
// tb_xup_rr_arbiter4: directed and model-checked bench for the round-robin arbiter with MAX_HOLD=4
module tb_xup_rr_arbiter4;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'hF;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid, any_req, preempt;

    int errors = 0;
    int checks = 0;

    int owner = -1;
    int ptr = 0;
    int held = 0;
    bit pre = 1'b0;

    xup_rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .any_req  (any_req),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", n, $time, a, e);
        end
    endtask

    function automatic int pick(input int p, input int excl);
        for (int k = 0; k < 4; k++) begin
            int j = (p + k) % 4;
            if (req[j] && j != excl) return j;
        end
        return -1;
    endfunction

    // owner/ptr/held model: held counts grant cycles the owner will have shown after this edge
    always @(posedge clk) begin
        if (reset) begin
            owner = -1; ptr = 0; held = 0; pre = 1'b0;
        end else if (owner < 0) begin
            owner = pick(ptr, -1); held = (owner >= 0) ? 1 : 0; pre = 1'b0;
        end else if (!req[owner]) begin
            ptr = (owner + 1) % 4; owner = pick(ptr, -1); held = 1; pre = 1'b0;
        end else if (held == MAXH && pick(0, owner) >= 0) begin
            ptr = (owner + 1) % 4; owner = pick(ptr, owner); held = 1; pre = 1'b1;
        end else begin
            held = (held == MAXH) ? 1 : held + 1; pre = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("m_gnt", 8'(gnt), owner < 0 ? 8'h0 : 8'(1 << owner));
        chk("m_valid", 8'(gnt_valid), 8'(owner >= 0));
        chk("m_preempt", 8'(preempt), 8'(pre));
        chk("m_any_req", 8'(any_req), 8'(|req));
        if (owner >= 0) chk("m_gnt_id", 8'(gnt_id), 8'(owner));
    end

    task automatic reset_pulse();
        reset = 1'b1;
        req = 4'h0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        repeat (2) begin
            @(negedge clk);
            chk("t1_reset_gnt", 8'(gnt), 8'h0);
            chk("t1_reset_valid", 8'(gnt_valid), 8'h0);
            chk("t1_reset_preempt", 8'(preempt), 8'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("t1_first_gnt", 8'(gnt), 8'h01);
        for (int i = 0; i < 5; i++) begin
            chk("t3_fair_gnt", 8'(gnt), 8'(1 << order[i]));
            repeat (2) @(negedge clk);
            req = 4'hF & ~(4'b1 << order[i]);
            @(negedge clk);
            req = 4'hF;
        end
        req = 4'h0;
        @(negedge clk);
        chk("t3_idle", 8'(gnt), 8'h0);

        reset_pulse();
        req = 4'b1010;
        @(negedge clk);
        chk("t2_gnt", 8'(gnt), 8'h02);
        chk("t2_gnt_id", 8'(gnt_id), 8'h01);
        req = 4'b1000;
        @(negedge clk);
        chk("t2_handover", 8'(gnt), 8'h08);
        req = 4'b0000;
        @(negedge clk);
        chk("t2_idle_gnt", 8'(gnt), 8'h0);
        chk("t2_idle_valid", 8'(gnt_valid), 8'h0);

        reset_pulse();
        req = 4'b0101;
        repeat (4) begin
            @(negedge clk);
            chk("t4_hold_gnt", 8'(gnt), 8'h01);
            chk("t4_hold_preempt", 8'(preempt), 8'h0);
        end
        @(negedge clk);
        chk("t4_preempt_gnt", 8'(gnt), 8'h04);
        chk("t4_preempt_pulse", 8'(preempt), 8'h01);
        @(negedge clk);
        chk("t4_preempt_low", 8'(preempt), 8'h0);
        req = 4'h0;
        @(negedge clk);

        reset_pulse();
        req = 4'b0001;
        repeat (20) begin
            @(negedge clk);
            chk("t5_alone_gnt", 8'(gnt), 8'h01);
            chk("t5_alone_preempt", 8'(preempt), 8'h0);
        end
        req = 4'h0;
        @(negedge clk);

        reset_pulse();
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("t6_pre_reset", 8'(gnt), 8'h04);
        reset = 1'b1;
        req = 4'b0110;
        @(negedge clk);
        chk("t6_reset_drop", 8'(gnt), 8'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ptr_zero", 8'(gnt), 8'h02);

        for (int c = 0; c < 400; c++) begin
            req = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        req = 4'h0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
